// File: rtl/ysyx_23060332_lsu_pkg.sv
// Shared definitions for the load/store unit and the physical-memory block:
// bus widths, legal address window, funct3 encodings and FSM states.
package ysyx_23060332_lsu_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  localparam logic [MEM_ADDR_W-1:0] MEM_BASE_DEF  = 32'h8000_0000;
  localparam logic [MEM_ADDR_W-1:0] MEM_LIMIT_DEF = 32'h87ff_ffff;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

  function automatic logic [MEM_ADDR_W-1:0] word_addr(input logic [MEM_ADDR_W-1:0] a);
    return {a[MEM_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_23060332_lsu_align.sv
// Byte-lane steering: store data/mask placement and load extraction with
// sign/zero extension. Purely combinational.
module ysyx_23060332_lsu_align
  import ysyx_23060332_lsu_pkg::*;
(
  input  logic [1:0]            st_size,
  input  logic [1:0]            st_off,
  input  logic [MEM_DATA_W-1:0] st_wdata,
  output logic [MEM_DATA_W-1:0] st_data,
  output logic [7:0]            st_mask,
  input  logic [2:0]            ld_funct3,
  input  logic [1:0]            ld_off,
  input  logic [MEM_DATA_W-1:0] ld_word,
  output logic [MEM_DATA_W-1:0] ld_data
);

  logic        [3:0]            lane_mask;
  logic        [MEM_DATA_W-1:0] ld_shift;
  logic signed [7:0]            ld_byte;
  logic signed [15:0]           ld_half;

  always_comb begin
    lane_mask = 4'b0000;
    case (st_size)
      2'b00:   lane_mask = 4'b0001 << st_off;
      2'b01:   lane_mask = 4'b0011 << st_off;
      default: lane_mask = 4'b1111;
    endcase
  end

  assign st_mask  = {4'b0000, lane_mask};
  assign st_data  = st_wdata << {st_off, 3'b000};

  assign ld_shift = ld_word >> {ld_off, 3'b000};
  assign ld_byte  = ld_shift[7:0];
  assign ld_half  = ld_shift[15:0];

  // Size casts of the signed slices replicate their top bit.
  always_comb begin
    ld_data = ld_shift;
    case (ld_funct3)
      LSU_B:   ld_data = MEM_DATA_W'(ld_byte);
      LSU_BU:  ld_data = {{(MEM_DATA_W-8){1'b0}}, ld_shift[7:0]};
      LSU_H:   ld_data = MEM_DATA_W'(ld_half);
      LSU_HU:  ld_data = {{(MEM_DATA_W-16){1'b0}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: EXU handshake in, registered word-aligned memory port with
// a fixed SRAM latency, extended result back to WBU.
module ysyx_23060332_lsu
  import ysyx_23060332_lsu_pkg::*;
#(
  parameter int          LATENCY   = 1,
  parameter logic [31:0] MEM_BASE  = MEM_BASE_DEF,
  parameter logic [31:0] MEM_LIMIT = MEM_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_ren,
  input  logic                  in_wen,
  input  logic [2:0]            in_funct3,
  input  logic [MEM_ADDR_W-1:0] in_addr,
  input  logic [MEM_DATA_W-1:0] in_wdata,
  input  logic [4:0]            in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MEM_DATA_W-1:0] out_rdata,
  output logic [4:0]            out_rd,
  output logic                  out_err,
  output logic                  mem_ren,
  output logic [MEM_ADDR_W-1:0] mem_raddr,
  input  logic [MEM_DATA_W-1:0] mem_rdata,
  output logic                  mem_wen,
  output logic [MEM_ADDR_W-1:0] mem_waddr,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  output logic [7:0]            mem_wmask
);

  localparam int CNT_W = $clog2(LATENCY + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  lsu_state_e             state;
  logic [CNT_W-1:0]       cnt;
  logic [1:0]             off_r;
  logic [2:0]             funct3_r;
  logic                   ren_r;

  logic                   acc_op, in_range, mis_align, bad_funct3, acc_err;
  logic [MEM_DATA_W-1:0]  st_data, ld_data, resp_data;
  logic [7:0]             st_mask;

  assign in_ready   = (state == ST_IDLE);

  // Every error is decided from the request itself, so nothing faulty reaches memory.
  assign acc_op     = in_ren | in_wen;
  assign in_range   = (in_addr >= MEM_BASE) && (in_addr <= MEM_LIMIT);
  assign mis_align  = ((in_funct3 == LSU_H || in_funct3 == LSU_HU) && in_addr[0]) ||
                      ((in_funct3 == LSU_W) && (in_addr[1:0] != 2'b00));
  assign bad_funct3 = in_wen ? in_funct3[2]
                             : ((in_funct3 == 3'b011) || (in_funct3[2:1] == 2'b11));
  assign acc_err    = acc_op && (!in_range || mis_align || bad_funct3 || (in_ren && in_wen));

  ysyx_23060332_lsu_align u_align (
    .st_size   (in_funct3[1:0]),
    .st_off    (in_addr[1:0]),
    .st_wdata  (in_wdata),
    .st_data   (st_data),
    .st_mask   (st_mask),
    .ld_funct3 (funct3_r),
    .ld_off    (off_r),
    .ld_word   (mem_rdata),
    .ld_data   (ld_data)
  );

  assign resp_data = ren_r ? ld_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      off_r     <= '0;
      funct3_r  <= '0;
      ren_r     <= 1'b0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_rdata <= '0;
      out_rd    <= '0;
      mem_ren   <= 1'b0;
      mem_raddr <= '0;
      mem_wen   <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      mem_wen <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            off_r    <= in_addr[1:0];
            funct3_r <= in_funct3;
            ren_r    <= in_ren;
            out_rd   <= in_rd;
            out_err  <= acc_err;
            if (acc_err || !acc_op) begin
              out_rdata <= '0;
              out_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              state <= ST_ACCESS;
              if (in_ren) begin
                mem_ren   <= 1'b1;
                mem_raddr <= word_addr(in_addr);
              end else begin
                mem_wen   <= 1'b1;
                mem_waddr <= word_addr(in_addr);
                mem_wdata <= st_data;
                mem_wmask <= st_mask;
              end
            end
          end
        end
        ST_ACCESS: begin
          if (LATENCY == 0) begin
            mem_ren   <= 1'b0;
            out_rdata <= resp_data;
            out_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt   <= '0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == CNT_LAST) begin
            mem_ren   <= 1'b0;
            out_rdata <= resp_data;
            out_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ysyx_23060332_lsu.md
Name: ysyx_23060332_lsu

Overview:
Load/store unit directly upstream of the physical-memory block. It accepts one load or store per transaction from EXU over a valid/ready handshake and checks alignment and address range. It drives the word-aligned memory port (ren/raddr, wen/waddr/wdata/wmask) and models a configurable SRAM latency. It then extracts and sign/zero-extends load data and returns the result to WBU over a second valid/ready handshake.

Parameters:
LATENCY, 1, number of WAIT cycles between issuing the access and sampling mem_rdata (0 legal)
MEM_BASE, 32'h80000000, lowest legal physical address
MEM_LIMIT, 32'h87ffffff, highest legal physical address (inclusive)

Ports:
clk  in  1  clock; all state changes on posedge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EXU request valid
in_ready  out  1  LSU can accept; high only in IDLE
in_ren  in  1  request is a load
in_wen  in  1  request is a store (in_ren & in_wen both high is illegal -> err)
in_funct3  in  3  RV32 funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
in_addr  in  32  effective byte address
in_wdata  in  32  store data (rs2)
in_rd  in  5  destination register, passed through
out_valid  out  1  result valid to WBU
out_ready  in  1  WBU accepts
out_rdata  out  32  extended load data; 0 for stores/errors
out_rd  out  5  registered in_rd
out_err  out  1  misaligned, out-of-range, or illegal op
mem_ren  out  1  read enable
mem_raddr  out  32  word-aligned read address (addr & ~3)
mem_rdata  in  32  combinational read data for mem_raddr
mem_wen  out  1  write enable; single-cycle pulse
mem_waddr  out  32  word-aligned write address
mem_wdata  out  32  store data shifted to byte lane
mem_wmask  out  8  byte mask; [7:4] always 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, out_err=0, out_rdata=0, out_rd=0, mem_ren=0, mem_wen=0, mem_raddr/waddr/wdata/wmask=0; wait counter=0.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: in_ready=1. On in_valid&in_ready, register addr, funct3, wdata, rd, ren, wen.
  - Error check, resolved at acceptance:
    - addr outside [MEM_BASE, MEM_LIMIT] with ren|wen -> err.
    - h/hu with addr[0]=1 -> err.
    - w with addr[1:0]!=0 -> err.
    - funct3 not legal for the op (store 1xx, load 011/11x) -> err.
    - ren&wen -> err.
  - If err, or neither ren nor wen: go to RESP, no memory access, out_rdata=0.
  - Otherwise go to ACCESS.
- ACCESS (1 cycle):
  - Load: mem_ren=1, mem_raddr=addr&~3.
  - Store: mem_wen=1, mem_waddr=addr&~3, mem_wdata=wdata<<(8*addr[1:0]). wmask is 0001<<off for b, 0011<<off for h, 1111 for w.
  - Next state: WAIT if LATENCY>0, else RESP. A load with LATENCY=0 samples mem_rdata at this edge.
- WAIT: counter counts LATENCY cycles. Loads hold mem_ren and mem_raddr; mem_wen=0. On the last WAIT cycle, loads sample mem_rdata; go to RESP.
- Load extraction: the sampled word is shifted right by 8*addr[1:0]. b sign-extends bit 7, bu zero-extends [7:0], h sign-extends bit 15, hu zero-extends [15:0], w passes through.
- RESP: out_valid=1 and all out_* held stable until out_ready; on out_valid&out_ready go to IDLE. mem_ren=0.
- Latency from handshake edge to out_valid:
  - Memory op: LATENCY+2 cycles.
  - Error or no-op: 1 cycle.
- Back-to-back: new accept only in IDLE, so the minimum period is LATENCY+3 cycles (RESP handshake cycle included).
- mem_wen is high in exactly one cycle per store and never for an erroring store.
- Reset mid-operation returns to IDLE immediately. A store whose ACCESS-cycle edge has not occurred is not written.
- All mem_* outputs are registered (no combinational path from in_* to mem_*).

Decomposition:
- Shared define file:
  - funct3 encodings (LSU_B/H/W/BU/HU).
  - FSM state encodings.
  - MEM_BASE/MEM_LIMIT defaults, reused by the memory block's valid check.
  - `MemAddrBus/`MemDataBus widths.
- One natural sub-module: ysyx_23060332_lsu_align, purely combinational. It provides store lane shift plus wmask generation, and load shift plus sign/zero extension. The FSM stays in the top.

Test Plan:
- lw 0x80000004, mem word 0xdeadbeef, LATENCY=1 -> mem_ren high 2 cycles at raddr 0x80000004; out_valid 3 cycles after accept; out_rdata=0xdeadbeef, err=0.
- lb 0x80000003, word 0x80ffffff -> raddr 0x80000000, out_rdata=0xffffff80. Same with lbu -> 0x00000080.
- sh 0x80000002, wdata 0x1234abcd -> one-cycle mem_wen, waddr 0x80000000, wdata 0xabcd0000, wmask 8'h0c; subsequent lhu 0x80000002 returns 0x0000abcd.
- lw 0x80000002 and sw 0x70000000 -> out_err=1 one cycle after accept, mem_ren=mem_wen=0 throughout, out_rdata=0.
- out_ready held low 5 cycles in RESP -> out_valid, out_rdata, out_rd stable, in_ready=0; accept resumes only after handshake.
- rst_n pulled low during WAIT of a load and during IDLE->ACCESS of a store -> all outputs 0 asynchronously, no mem_wen pulse, in_ready=1 after release.
